fft_result_serializer: RTL
==========================

Name: fft_result_serializer

Overview:
- Downstream stage of the 16-point FFT core. Replaces the ad hoc byte counter and 32:1 byte mux that currently sit in front of UART_TX.
- Captures one complete frame of real FFT outputs on the FFT's cycle-done pulse into a shadow register.
- Streams the captured frame byte by byte to UART_TX using a start/done handshake.
- Reports busy, frame completion and overrun.

Parameters:
- FFT_SIZE, 16, number of FFT output words per frame
- WORD_SIZE, 16, width of each FFT output word; must be an integer multiple of DATA_LENGTH
- DATA_LENGTH, 8, UART byte width
- HEADER_BYTE, 8'hA5, sync byte; used only when SERIALIZER_HDR_EN is defined

Ports:
- i_clk  in  1  system clock; all state changes on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_frame_valid  in  1  one-cycle pulse: i_frame_data holds a complete FFT result
- i_frame_data  in  FFT_SIZE*WORD_SIZE  packed outputs; word k occupies bits [k*WORD_SIZE +: WORD_SIZE]
- o_tx_start  out  1  one-cycle start pulse to UART_TX
- o_tx_byte  out  DATA_LENGTH  byte to transmit; stable from the o_tx_start cycle until i_tx_done
- i_tx_done  in  1  one-cycle pulse from UART_TX: current byte fully sent
- o_busy  out  1  high from frame capture until the last i_tx_done
- o_frame_done  out  1  one-cycle pulse after the last byte of a frame completes
- o_overrun  out  1  sticky: a frame arrived while busy

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0, all state clears:
  - state=IDLE, byte index=0, shadow register=0
  - o_tx_start=0, o_tx_byte=0, o_busy=0, o_frame_done=0, o_overrun=0
- Derived sizes:
  - BPW = WORD_SIZE/DATA_LENGTH (2 with defaults)
  - NBYTES = FFT_SIZE*BPW (32 with defaults)
  - The byte index counter is clog2(NBYTES+1) bits wide.
- Byte order: byte j = word j/BPW, slice [(j%BPW)*DATA_LENGTH +: DATA_LENGTH]. With defaults this is LSB byte first, word 0 first, so byte0=word0[7:0] and byte1=word0[15:8].
- Outputs are registered; none are combinational from inputs.
- State machine has three states: IDLE, SEND, WAIT.
- IDLE:
  - o_busy=0.
  - On i_frame_valid=1: copy i_frame_data into the shadow register, set index=0, set o_busy=1, go to SEND.
- SEND:
  - Lasts one cycle. o_tx_start=1, o_tx_byte=byte[index].
  - Go to WAIT.
- WAIT:
  - o_tx_start=0; o_tx_byte held.
  - On i_tx_done with index<NBYTES-1: index+1, go to SEND.
  - On i_tx_done with index=NBYTES-1: o_frame_done=1 for one cycle, o_busy=0, index=0, go to IDLE.
- Latency:
  - i_frame_valid sampled at edge k: o_tx_start is high in the cycle after edge k.
  - i_tx_done sampled at edge m: next o_tx_start is high in the cycle after edge m.
- Timing: a 32-byte frame takes 32 UART byte times plus 32 clocks of overhead.
- Boundary conditions:
  - Shadow register is written only in IDLE. i_frame_data may change freely once the frame is accepted.
  - i_frame_valid while o_busy=1 (SEND or WAIT): the frame is dropped and o_overrun is set. o_overrun stays 1 until reset. Transmission in progress is unaffected.
  - i_frame_valid in the same cycle as the final i_tx_done: the state is still WAIT, so it is treated as overrun and dropped.
  - i_tx_done in IDLE or SEND: ignored. No index change, no extra start pulse.
  - Reset asserted mid-frame: aborts immediately and clears all outputs. o_tx_start never glitches high during or after reset release.
  - i_frame_valid held high for several cycles: the first cycle is accepted and later cycles count as overrun.

Optional Feature:
- Macro: SERIALIZER_HDR_EN.
- Defined:
  - HEADER_BYTE is sent before the frame, so NBYTES_TOTAL=NBYTES+1 (33 with defaults).
  - The first SEND after capture drives HEADER_BYTE. Data bytes follow in the same order as above.
  - o_frame_done fires after byte 33.
- Not defined: no header; 32 bytes per frame; HEADER_BYTE unused.

Test Plan:
- Capture and order: load word k=16'h0100*k+k (word0=0000, word1=0101, ..., word15=0F0F) and pulse i_frame_valid. Model UART_TX with i_tx_done 10 clocks after each start. Required: exactly 32 start pulses with bytes 00,00,01,01,...,0F,0F; o_frame_done one cycle after the 32nd done; o_busy low afterwards.
- Data stability: change i_frame_data to all 16'hFFFF one cycle after capture. Required: the transmitted stream still matches the captured frame; o_tx_byte is constant between each start and its done.
- Overrun: pulse i_frame_valid again during byte 5. Required: o_overrun=1 and sticky; stream continues to 32 bytes; no restart. Also pulse i_frame_valid in the same cycle as the final i_tx_done. Required: frame dropped, o_overrun=1.
- Spurious done: pulse i_tx_done while in IDLE and during the SEND cycle. Required: no o_tx_start, index unchanged, byte count per frame still 32.
- Reset mid-frame: assert i_rst_n=0 asynchronously (between clock edges) during byte 12. Required: all outputs 0 immediately. After release, a new frame starts transmitting from byte0.
- SERIALIZER_HDR_EN build: run the same frame as the first scenario. Required: first byte A5, then 32 data bytes; o_frame_done after the 33rd i_tx_done.

Source files
------------

// File: rtl/fft_result_serializer.sv
// fft_result_serializer: captures one FFT frame into a shadow register and streams it byte by byte to UART_TX.
// Ports: i_clk/i_rst_n (async active-low reset); i_frame_valid/i_frame_data frame capture;
//        o_tx_start/o_tx_byte/i_tx_done UART handshake; o_busy, o_frame_done, o_overrun status.
// Optional: define SERIALIZER_HDR_EN to prefix each frame with HEADER_BYTE.
module fft_result_serializer #(
  parameter int FFT_SIZE = 16,
  parameter int WORD_SIZE = 16,
  parameter int DATA_LENGTH = 8,
  parameter logic [DATA_LENGTH-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_frame_valid,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] i_frame_data,
  output logic                          o_tx_start,
  output logic [DATA_LENGTH-1:0]        o_tx_byte,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_overrun
);
  localparam int BPW = WORD_SIZE / DATA_LENGTH;
  localparam int NBYTES = FFT_SIZE * BPW;
  localparam int IW = $clog2(NBYTES + 1);
`ifdef SERIALIZER_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [IW-1:0] LAST = IW'(NBYTES + HDR - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [FFT_SIZE*WORD_SIZE-1:0]   shadow_q, shadow_d;
  logic                            tx_start_q, tx_start_d;
  logic [DATA_LENGTH-1:0]          tx_byte_q, tx_byte_d;
  logic                            busy_q, busy_d;
  logic                            frame_done_q, frame_done_d;
  logic                            overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (i_frame_valid && state_q != IDLE);
    if (state_q == IDLE && i_frame_valid) begin
      shadow_d = i_frame_data;
      idx_d    = '0;
      busy_d   = 1'b1;
      state_d  = SEND;
    end else if (state_q == SEND) begin
      state_d = WAIT;
    end else if (state_q == WAIT && i_tx_done) begin
      if (idx_q == LAST) begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        idx_d        = '0;
        state_d      = IDLE;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = SEND;
      end
    end
    // Byte j sits at bit offset j*DATA_LENGTH; on capture the byte comes straight from the incoming frame via shadow_d.
    if (state_d == SEND) begin
      tx_start_d = 1'b1;
      tx_byte_d  = (HDR != 0 && idx_d == '0) ? HEADER_BYTE
                 : shadow_d[(idx_d - IW'(HDR)) * DATA_LENGTH +: DATA_LENGTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;
endmodule
